// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, framing constants
// and the bit-period helper.
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int DEFAULT_BAUD = 115200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    // Truncating divide; the resulting baud error is accepted, no fractional divider.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (serial pins, I2C lines).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and
// single-cycle framing-error / overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 48000000,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic                 ref_clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 deliver;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i (ref_clk),
        .rst_ni(rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;

        // A consume in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level model of
// the receiver and its one-entry holding register.
module tb_uart_rx;

    localparam int CPB = 48000000 / 115200;

    logic       ref_clk  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    longint cycleCount    = 0;
    longint lastRiseCycle = -1;
    int     frameErrSeen  = 0;
    int     overrunSeen   = 0;
    int     validRises    = 0;
    logic   prevValid     = 1'b0;
    logic [7:0] acceptedQ[$];

    logic [7:0] expQ[$];
    logic [7:0] mData       = 8'h00;
    logic       mValid      = 1'b0;
    int         expFrameErr = 0;
    int         expOverrun  = 0;

    uart_rx dut (
        .ref_clk  (ref_clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cycleCount++;

    // Observe outputs mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge ref_clk) begin
        if (rst_n) begin
            if (frame_err) frameErrSeen++;
            if (overrun) overrunSeen++;
            if (rx_valid && !prevValid) begin
                lastRiseCycle = cycleCount;
                validRises++;
            end
            if (rx_valid && rx_ready) acceptedQ.push_back(rx_data);
            prevValid = rx_valid;
        end else begin
            prevValid = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level receiver model: what the holding register and pulse counters must show.
    task automatic modelFrame(input logic [7:0] b, input bit stopOk, input bit rdyAtDeliver,
                              input bit rdyAfter);
        if (!stopOk) begin
            expFrameErr++;
            return;
        end
        if (!mValid) begin
            mData  = b;
            mValid = 1'b1;
        end else if (rdyAtDeliver) begin
            expQ.push_back(mData);
            mData = b;
        end else begin
            expOverrun++;
        end
        if (rdyAfter && mValid) begin
            expQ.push_back(mData);
            mValid = 1'b0;
        end
    endtask

    task automatic modelConsume();
        if (mValid) begin
            expQ.push_back(mData);
            mValid = 1'b0;
        end
    endtask

    task automatic holdLine(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(posedge ref_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        holdLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdLine(b[i], CPB);
        holdLine(stopBit, CPB);
    endtask

    task automatic pulseReady();
        rx_ready = 1'b1;
        @(posedge ref_clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        longint startCycle;
        int     risesBefore;
        int     ovrBefore;
        logic [7:0] b;

        repeat (5) @(posedge ref_clk);
        #1;
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_data", rx_data, 8'h00);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ferr", frame_err, 0);
        checkOutput("reset_ovr", overrun, 0);
        rst_n = 1'b1;
        holdLine(1'b1, 20);

        // 0x55 with consumer always ready; check delivery latency.
        rx_ready      = 1'b1;
        lastRiseCycle = -1;
        startCycle    = cycleCount;
        applyStimulus(8'h55, 1'b1);
        modelFrame(8'h55, 1'b1, 1'b1, 1'b1);
        begin
            longint lat;
            lat = lastRiseCycle - startCycle;
            checkOutput("latency", (lat >= 3954 && lat <= 3956) ? 32'd3955 : 32'(lat), 3955);
        end
        checkOutput("valid_after_55", rx_valid, 0);
        holdLine(1'b1, 50);

        // Short low glitch must be rejected at the mid-start sample.
        risesBefore = validRises;
        holdLine(1'b0, 100);
        holdLine(1'b1, 50);
        checkOutput("glitch_busy_mid", busy, 1);
        holdLine(1'b1, 80);
        checkOutput("glitch_busy_end", busy, 0);
        checkOutput("glitch_no_valid", validRises - risesBefore, 0);
        holdLine(1'b1, 200);

        // Bad stop bit followed by a long break, then a good frame.
        applyStimulus(8'hA5, 1'b0);
        modelFrame(8'hA5, 1'b0, 1'b1, 1'b1);
        holdLine(1'b0, 2000);
        checkOutput("break_busy", busy, 1);
        holdLine(1'b1, CPB);
        checkOutput("break_idle", busy, 0);
        applyStimulus(8'h3C, 1'b1);
        modelFrame(8'h3C, 1'b1, 1'b1, 1'b1);
        holdLine(1'b1, 50);

        // Overrun: two bytes with nobody consuming.
        rx_ready  = 1'b0;
        ovrBefore = overrunSeen;
        applyStimulus(8'h11, 1'b1);
        modelFrame(8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b1);
        modelFrame(8'h22, 1'b1, 1'b0, 1'b0);
        holdLine(1'b1, 50);
        checkOutput("ovr_valid", rx_valid, mValid);
        checkOutput("ovr_data", rx_data, mData);
        checkOutput("ovr_pulses", overrunSeen - ovrBefore, 1);
        pulseReady();
        modelConsume();
        checkOutput("consume_valid", rx_valid, 0);
        checkOutput("consume_data_held", rx_data, 8'h11);
        holdLine(1'b1, 50);

        // Consume exactly in the delivery cycle of the second byte.
        applyStimulus(8'h11, 1'b1);
        modelFrame(8'h11, 1'b1, 1'b0, 1'b0);
        holdLine(1'b1, 50);
        ovrBefore = overrunSeen;
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                repeat (3954) @(posedge ref_clk);
                #1;
                pulseReady();
            end
        join
        modelFrame(8'h22, 1'b1, 1'b1, 1'b0);
        holdLine(1'b1, 20);
        checkOutput("swap_no_ovr", overrunSeen - ovrBefore, 0);
        checkOutput("swap_valid", rx_valid, mValid);
        checkOutput("swap_data", rx_data, mData);
        pulseReady();
        modelConsume();
        holdLine(1'b1, 50);

        // Reset in the middle of data bit 4 of 0x99.
        rx_ready = 1'b1;
        b        = 8'h99;
        holdLine(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdLine(b[i], CPB);
        holdLine(b[4], CPB / 2);
        rst_n  = 1'b0;
        rx     = 1'b1;
        mValid = 1'b0;
        mData  = 8'h00;
        holdLine(1'b1, 5);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_valid", rx_valid, 0);
        checkOutput("midreset_data", rx_data, 8'h00);
        rst_n = 1'b1;
        holdLine(1'b1, 100);
        applyStimulus(8'h42, 1'b1);
        modelFrame(8'h42, 1'b1, 1'b1, 1'b1);

        // Random bytes with no idle gap between frames.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b1);
            modelFrame(b, 1'b1, 1'b1, 1'b1);
        end
        holdLine(1'b1, 100);

        checkOutput("frame_err_count", frameErrSeen, expFrameErr);
        checkOutput("overrun_count", overrunSeen, expOverrun);
        checkOutput("accepted_count", acceptedQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < acceptedQ.size())
                checkOutput($sformatf("byte%0d", i), acceptedQ[i], expQ[i]);
        end
        checkOutput("final_valid", rx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
